ysyx_axi4_mem_slave: RTL
========================

YSYX_AXI4_MEM_SLAVE -- requirements
Module: ysyx_axi4_mem_slave

Interface
REQ-001 SHALL have parameter BASE, default 32'h8000_0000, meaning byte address of word 0.
REQ-002 SHALL have parameter DEPTH_LOG2, default 12, meaning log2 of the number of 64-bit words.
REQ-003 SHALL have parameter RD_LAT, default 2, meaning idle cycles between AR handshake and first rvalid (0..15).
REQ-004 SHALL have port clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port arid  in  4  read ID.
REQ-007 SHALL have port araddr  in  32  read start byte address.
REQ-008 SHALL have port arlen  in  8  read beats minus 1.
REQ-009 SHALL have port arsize  in  3  log2 bytes per beat.
REQ-010 SHALL have port arvalid  in  1  AR valid.
REQ-011 SHALL have port arready  out  1  AR ready.
REQ-012 SHALL have port rid  out  4  captured arid.
REQ-013 SHALL have port rdata  out  64  read word.
REQ-014 SHALL have port rresp  out  2  00 OKAY, 10 SLVERR.
REQ-015 SHALL have port rlast  out  1  final read beat.
REQ-016 SHALL have port rvalid  out  1  R valid.
REQ-017 SHALL have port rready  in  1  R ready.
REQ-018 SHALL have port awid  in  4  write ID.
REQ-019 SHALL have port awaddr  in  32  write start byte address.
REQ-020 SHALL have port awlen  in  8  write beats minus 1.
REQ-021 SHALL have port awsize  in  3  log2 bytes per beat.
REQ-022 SHALL have port awvalid  in  1  AW valid.
REQ-023 SHALL have port awready  out  1  AW ready.
REQ-024 SHALL have port wdata  in  64  write word.
REQ-025 SHALL have port wstrb  in  8  byte enables.
REQ-026 SHALL have port wlast  in  1  final write beat.
REQ-027 SHALL have port wvalid  in  1  W valid.
REQ-028 SHALL have port wready  out  1  W ready.
REQ-029 SHALL have port bid  out  4  captured awid.
REQ-030 SHALL have port bresp  out  2  00 OKAY, 10 SLVERR.
REQ-031 SHALL have port bvalid  out  1  B valid.
REQ-032 SHALL have port bready  in  1  B ready.

Function
REQ-033 Read FSM SHALL be R_IDLE (arready=1) -> R_WAIT on AR handshake (capture id/addr/len/size, count RD_LAT cycles; skipped if RD_LAT=0) -> R_DATA -> R_IDLE after rlast handshake.
REQ-034 In R_DATA rvalid SHALL be 1 with rdata/rresp/rlast/rid stable until rready; beat advances only on rvalid&rready; rlast=1 on beat arlen.
REQ-035 Beat address SHALL increment by 1<<size per beat (INCR); word index = (addr-BASE)>>3; narrow beats return the full 64-bit word.
REQ-036 Write FSM SHALL be W_IDLE (awready=1) -> W_DATA on AW handshake (wready=1) -> W_RESP after beat awlen accepted (bvalid=1) -> W_IDLE on bready.
REQ-037 Each accepted W beat SHALL update only bytes with wstrb=1 at the current word, visible to reads starting the next cycle.
REQ-038 Beats with address outside [BASE, BASE+8<<DEPTH_LOG2) or size>3 SHALL give rresp=10 with rdata=0, or suppress the memory write and set bresp=10.
REQ-039 wlast disagreeing with beat count SHALL set bresp=10; burst still ends at beat awlen.
REQ-040 Read and write channels SHALL run concurrently; same-cycle read/write of one word returns old data.

Reset
REQ-041 On rst, both FSMs SHALL enter idle, counters clear, memory unchanged; outputs: arready=1, awready=1, rvalid=0, rlast=0, wready=0, bvalid=0, rdata=0, rresp=0, rid=0, bresp=0, bid=0; in-flight bursts are dropped.

Verification
REQ-042 Write BASE, len 0, size 3, wdata 64'h1122334455667788, wstrb FF; read back -> bresp 00, rvalid 2 cycles after AR handshake, rdata matches, rlast 1.
REQ-043 4-beat write, wstrb 0F, then 4-beat read len 3 -> upper 32 bits unchanged, rlast only on beat 3.
REQ-044 Read with rready low 5 cycles -> rvalid and rdata held stable, no beat skipped.
REQ-045 araddr 32'h0000_1000 -> rresp 10, rdata 0; awaddr 32'h0000_1000 -> bresp 10, memory unchanged.
REQ-046 rst asserted mid 8-beat read -> rvalid 0 next cycle, arready 1, fresh read served correctly.

Source files
------------

// File: rtl/ysyx_axi4_mem_slave.sv
// ysyx_axi4_mem_slave: AXI4 memory slave with a 64-bit word array,
// independent read and write burst engines and configurable read latency.
//
// Parameters:
//   BASE        byte address of word 0
//   DEPTH_LOG2  log2 of the number of 64-bit words
//   RD_LAT      idle cycles between AR handshake and first rvalid (0..15)
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   arid/araddr/arlen/arsize          read address channel payload
//   arvalid/arready                   read address handshake
//   rid/rdata/rresp/rlast             read data channel payload
//   rvalid/rready                     read data handshake
//   awid/awaddr/awlen/awsize          write address channel payload
//   awvalid/awready                   write address handshake
//   wdata/wstrb/wlast                 write data channel payload
//   wvalid/wready                     write data handshake
//   bid/bresp                         write response payload
//   bvalid/bready                     write response handshake
//
// Responses: 00 OKAY, 10 SLVERR (beat outside the array, size > 3,
// or a wlast that disagrees with the burst length).

module ysyx_axi4_mem_slave #(
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          RD_LAT     = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic        arvalid,
    output logic        arready,

    output logic [3:0]  rid,
    output logic [63:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,

    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic        awvalid,
    output logic        awready,

    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,

    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int          WORDS     = 1 << DEPTH_LOG2;
    localparam logic [32:0] MEM_BYTES = 33'd8 << DEPTH_LOG2;

    // Terminal value of the latency counter in R_WAIT.
    localparam logic [3:0] LAT_LAST =
        (RD_LAT == 0) ? 4'd0 : 4'(RD_LAT - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    logic [63:0] mem [WORDS];

    // A beat is serviceable when its address lies in the array
    // and its size fits the 64-bit bus.
    function automatic logic beat_ok(
        input logic [31:0] a,
        input logic [2:0]  sz
    );
        logic [32:0] off;
        off = {1'b0, a - BASE};
        return (off < MEM_BYTES) && (sz <= 3'd3);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] word_idx(
        input logic [31:0] a
    );
        logic [31:0] off;
        off = (a - BASE) >> 3;
        return DEPTH_LOG2'(off);
    endfunction

    function automatic logic [31:0] beat_inc(
        input logic [2:0] sz
    );
        return 32'd1 << sz;
    endfunction

    // ------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------
    logic [1:0]  r_state;
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic [2:0]  r_size;
    logic [7:0]  r_beat;
    logic [3:0]  wait_cnt;

    // Load port of the rdata register: which beat gets presented
    // on R at the coming edge. Loading at the edge (rather than
    // reading memory combinationally) keeps R stable under
    // backpressure and gives old data on a same-cycle write.
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [2:0]  ld_size;
    logic [7:0]  ld_beat;
    logic [7:0]  ld_len;
    logic        ld_ok;

    assign arready = (r_state == R_IDLE);
    assign rvalid  = (r_state == R_DATA);

    always_comb begin
        ld_en   = 1'b0;
        ld_addr = r_addr;
        ld_size = r_size;
        ld_beat = r_beat;
        ld_len  = r_len;
        unique case (r_state)
            R_IDLE: begin
                if (arvalid && (RD_LAT == 0)) begin
                    ld_en   = 1'b1;
                    ld_addr = araddr;
                    ld_size = arsize;
                    ld_beat = 8'd0;
                    ld_len  = arlen;
                end
            end
            R_WAIT: begin
                if (wait_cnt == LAT_LAST) begin
                    ld_en = 1'b1;
                end
            end
            R_DATA: begin
                if (rready && !rlast) begin
                    ld_en   = 1'b1;
                    ld_addr = r_addr + beat_inc(r_size);
                    ld_beat = r_beat + 8'd1;
                end
            end
            default: begin
            end
        endcase
    end

    assign ld_ok = beat_ok(ld_addr, ld_size);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= R_IDLE;
            r_addr   <= '0;
            r_len    <= '0;
            r_size   <= '0;
            r_beat   <= '0;
            wait_cnt <= '0;
            rid      <= '0;
            rdata    <= '0;
            rresp    <= RESP_OKAY;
            rlast    <= 1'b0;
        end else begin
            if (ld_en) begin
                rdata  <= ld_ok ? mem[word_idx(ld_addr)] : 64'd0;
                rresp  <= ld_ok ? RESP_OKAY : RESP_SLVERR;
                rlast  <= (ld_beat == ld_len);
                r_addr <= ld_addr;
                r_beat <= ld_beat;
            end
            unique case (r_state)
                R_IDLE: begin
                    if (arvalid) begin
                        rid      <= arid;
                        r_addr   <= araddr;
                        r_len    <= arlen;
                        r_size   <= arsize;
                        r_beat   <= 8'd0;
                        wait_cnt <= 4'd0;
                        r_state  <= (RD_LAT == 0) ? R_DATA : R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (wait_cnt == LAT_LAST) begin
                        r_state <= R_DATA;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                R_DATA: begin
                    if (rready && rlast) begin
                        r_state <= R_IDLE;
                        rdata   <= '0;
                        rresp   <= RESP_OKAY;
                        rlast   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------
    logic [1:0]  w_state;
    logic [31:0] w_addr;
    logic [7:0]  w_len;
    logic [2:0]  w_size;
    logic [7:0]  w_beat;
    logic        w_err;
    logic        w_ok;
    logic        w_fire;
    logic        w_final;

    assign awready = (w_state == W_IDLE);
    assign wready  = (w_state == W_DATA);
    assign bvalid  = (w_state == W_RESP);

    assign w_ok    = beat_ok(w_addr, w_size);
    assign w_fire  = wready && wvalid;
    assign w_final = (w_beat == w_len);

    // Array has no reset: contents survive rst, only bursts are lost.
    always_ff @(posedge clk) begin
        if (!rst && w_fire && w_ok) begin
            for (int i = 0; i < 8; i++) begin
                if (wstrb[i]) begin
                    mem[word_idx(w_addr)][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_beat  <= '0;
            w_err   <= 1'b0;
            bid     <= '0;
            bresp   <= RESP_OKAY;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (awvalid) begin
                        bid     <= awid;
                        w_addr  <= awaddr;
                        w_len   <= awlen;
                        w_size  <= awsize;
                        w_beat  <= 8'd0;
                        w_err   <= 1'b0;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        // The burst length, not wlast, ends the burst.
                        if (w_final) begin
                            w_state <= W_RESP;
                            bresp   <= (w_err || !w_ok || !wlast)
                                       ? RESP_SLVERR : RESP_OKAY;
                        end else begin
                            w_addr <= w_addr + beat_inc(w_size);
                            w_beat <= w_beat + 8'd1;
                            if (!w_ok || wlast) begin
                                w_err <= 1'b1;
                            end
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        w_state <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

endmodule
